// File: rtl/ibus_mem_responder_pkg.sv
// Shared definitions for the ireq/irsp instruction-fetch responder:
// privilege encodings, bus width and the response word format.
package ibus_mem_responder_pkg;

    localparam int unsigned C_XLEN = 32;

    localparam logic [1:0] HPL_U = 2'b00;
    localparam logic [1:0] HPL_S = 2'b01;
    localparam logic [1:0] HPL_M = 2'b11;

    typedef struct packed {
        logic              rerr;
        logic [C_XLEN-1:0] data;
    } rsp_t;

    // True when hpl < min_hpl; borrow-based so a zero minimum needs no constant compare
    function automatic logic hpl_below(input logic [1:0] hpl, input logic [1:0] min_hpl);
        logic [2:0] diff;
        diff = {1'b1, hpl} - {1'b0, min_hpl};
        return ~diff[2];
    endfunction

endpackage

// File: rtl/ibus_mem_responder_rsp_fifo.sv
// Synchronous response FIFO holding {rerr, data}; head reads as zero when empty.
// Accepts a push at full only together with a pop.
module rsp_fifo
    import ibus_mem_responder_pkg::*;
#(
    parameter int unsigned C_DEPTH_X = 2
) (
    input  logic               clk_i,
    input  logic               resetb_i,
    input  logic               push_i,
    input  rsp_t               wdata_i,
    input  logic               pop_i,
    output rsp_t               rdata_o,
    output logic               empty_o,
    output logic [C_DEPTH_X:0] count_o
);

    localparam int unsigned DEPTH = 1 << C_DEPTH_X;
    localparam logic [C_DEPTH_X-1:0] PTR_ONE = C_DEPTH_X'(1);
    localparam logic [C_DEPTH_X:0]   CNT_ONE = (C_DEPTH_X+1)'(1);

    rsp_t                 mem_q [DEPTH];
    logic [C_DEPTH_X-1:0] wptr_q, wptr_d;
    logic [C_DEPTH_X-1:0] rptr_q, rptr_d;
    logic [C_DEPTH_X:0]   count_q, count_d;
    logic                 full;
    logic                 do_push;
    logic                 do_pop;

    assign empty_o = (count_q == '0);
    // count never exceeds DEPTH, so its MSB alone marks full
    assign full    = count_q[C_DEPTH_X];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PTR_ONE;
        if (do_pop)  rptr_d = rptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ibus_mem_responder.sv
// Target-side ireq/irsp responder: decodes fetch errors, reads a synchronous SRAM and
// returns in-order responses through a credit-limited FIFO (1 fetch/cycle, latency 2).
module ibus_mem_responder
    import ibus_mem_responder_pkg::*;
#(
    parameter logic [31:0] C_ADDR_BASE   = 32'h0,
    parameter int unsigned C_MEM_SZX     = 10,
    parameter int unsigned C_RSP_DEPTH_X = 2,
    parameter logic [1:0]  C_MIN_HPL     = HPL_U
) (
    input  logic                 clk_i,
    input  logic                 resetb_i,
    input  logic                 clk_en_i,
    output logic                 ireqready_o,
    input  logic                 ireqvalid_i,
    input  logic [1:0]           ireqhpl_i,
    input  logic [C_XLEN-1:0]    ireqaddr_i,
    input  logic                 irspready_i,
    output logic                 irspvalid_o,
    output logic                 irsprerr_o,
    output logic [C_XLEN-1:0]    irspdata_o,
    output logic                 mem_en_o,
    output logic [C_MEM_SZX-1:0] mem_addr_o,
    input  logic [C_XLEN-1:0]    mem_rdata_i
);

    localparam logic [C_RSP_DEPTH_X:0] DEPTH_L = {1'b1, {C_RSP_DEPTH_X{1'b0}}};

    logic [32:0]            addr_off;
    logic                   req_err;
    logic                   accept;
    logic                   infl_valid_q, infl_valid_d;
    logic                   infl_err_q, infl_err_d;
    logic                   push;
    logic                   pop;
    rsp_t                   push_rsp;
    rsp_t                   head_rsp;
    logic                   fifo_empty;
    logic [C_RSP_DEPTH_X:0] fifo_count;
    logic [C_RSP_DEPTH_X:0] credits;

    // Base is window-aligned, so the offset's low bits equal the address's low bits;
    // a borrow into bit 32 flags addresses below the base.
    assign addr_off = {1'b0, ireqaddr_i} - {1'b0, C_ADDR_BASE};
    assign req_err  = (|addr_off[32:C_MEM_SZX+2])
                    | (|addr_off[1:0])
                    | hpl_below(ireqhpl_i, C_MIN_HPL);

    assign credits     = fifo_count + (C_RSP_DEPTH_X+1)'(infl_valid_q);
    assign ireqready_o = (credits < DEPTH_L);
    assign accept      = clk_en_i & ireqvalid_i & ireqready_o;

    assign mem_en_o   = accept & ~req_err;
    assign mem_addr_o = addr_off[C_MEM_SZX+1:2];

    always_comb begin
        infl_valid_d = infl_valid_q;
        infl_err_d   = infl_err_q;
        if (clk_en_i) begin
            infl_valid_d = accept;
            infl_err_d   = req_err;
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            infl_valid_q <= 1'b0;
            infl_err_q   <= 1'b0;
        end else begin
            infl_valid_q <= infl_valid_d;
            infl_err_q   <= infl_err_d;
        end
    end

    // Credits already reserved a slot at accept, so the push never waits
    assign push          = clk_en_i & infl_valid_q;
    assign push_rsp.rerr = infl_err_q;
    assign push_rsp.data = infl_err_q ? '0 : mem_rdata_i;
    assign pop           = clk_en_i & irspready_i & ~fifo_empty;

    rsp_fifo #(
        .C_DEPTH_X (C_RSP_DEPTH_X)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .resetb_i (resetb_i),
        .push_i   (push),
        .wdata_i  (push_rsp),
        .pop_i    (pop),
        .rdata_o  (head_rsp),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    assign irspvalid_o = ~fifo_empty;
    assign irsprerr_o  = head_rsp.rerr;
    assign irspdata_o  = head_rsp.data;

endmodule

// File: tb/tb_ibus_mem_responder.sv
// Scoreboard bench for ibus_mem_responder: a reference model queues expected responses
// at each accepted request; a negedge monitor checks handshakes, timing and data.
module tb_ibus_mem_responder;

    localparam logic [31:0] BASE    = 32'h0001_0000;
    localparam int unsigned SZX     = 6;
    localparam int unsigned WORDS   = 64;
    localparam int unsigned DEPTH   = 4;
    localparam logic [1:0]  MIN_HPL = 2'b11;

    logic        clk       = 1'b0;
    logic        resetb    = 1'b0;
    logic        clk_en    = 1'b0;
    logic        ireqvalid = 1'b0;
    logic [1:0]  ireqhpl   = 2'b11;
    logic [31:0] ireqaddr  = '0;
    logic        irspready = 1'b0;
    logic        ireqready_o;
    logic        irspvalid_o;
    logic        irsprerr_o;
    logic [31:0] irspdata_o;
    logic        mem_en_o;
    logic [5:0]  mem_addr_o;
    logic [31:0] mem_rdata = '0;

    ibus_mem_responder #(
        .C_ADDR_BASE   (BASE),
        .C_MEM_SZX     (SZX),
        .C_RSP_DEPTH_X (2),
        .C_MIN_HPL     (MIN_HPL)
    ) dut (
        .clk_i       (clk),
        .resetb_i    (resetb),
        .clk_en_i    (clk_en),
        .ireqready_o (ireqready_o),
        .ireqvalid_i (ireqvalid),
        .ireqhpl_i   (ireqhpl),
        .ireqaddr_i  (ireqaddr),
        .irspready_i (irspready),
        .irspvalid_o (irspvalid_o),
        .irsprerr_o  (irsprerr_o),
        .irspdata_o  (irspdata_o),
        .mem_en_o    (mem_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model: data appears the cycle after the read enable
    logic [31:0] mem_arr [WORDS];
    always @(posedge clk) begin
        if (mem_en_o) mem_rdata <= mem_arr[mem_addr_o];
    end

    typedef struct {
        logic        rerr;
        logic [31:0] data;
        int unsigned ready_at;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned total    = 0;
    int unsigned bad      = 0;
    int unsigned en_cnt   = 0;
    int unsigned acc_cnt  = 0;
    int unsigned dut_acc  = 0;
    int unsigned rsp_seen = 0;
    int unsigned dropped  = 0;
    logic        exp_ready    = 1'b1;
    logic        exp_mem_en   = 1'b0;
    logic [5:0]  exp_mem_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a, input logic [1:0] h);
        longint la;
        longint lb;
        la = longint'({32'h0, a});
        lb = longint'({32'h0, BASE});
        return (la < lb) || (la >= lb + longint'(4 * WORDS)) || (a[1:0] != 2'b00) || (h < MIN_HPL);
    endfunction

    // One clock cycle of stimulus; the model decides acceptance from its own credit count
    task automatic step(input bit v, input logic [31:0] a, input logic [1:0] h,
                        input bit ce, input bit rr);
        exp_t        e;
        bit          acc;
        bit          err;
        logic [31:0] widx;
        @(posedge clk);
        #1;
        ireqvalid = v;
        ireqaddr  = a;
        ireqhpl   = h;
        clk_en    = ce;
        irspready = rr;
        #2;
        exp_ready    = (sb_q.size() < DEPTH);
        acc          = ce && v && exp_ready;
        err          = model_err(a, h);
        widx         = (a - BASE) >> 2;
        exp_mem_en   = acc && !err;
        exp_mem_addr = widx[5:0];
        if (acc) begin
            acc_cnt++;
            e.rerr     = err;
            e.data     = err ? 32'h0 : mem_arr[widx[5:0]];
            e.ready_at = en_cnt + 2;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input int unsigned n, input bit rr);
        for (int unsigned i = 0; i < n; i++) step(1'b0, BASE, 2'b11, 1'b1, rr);
    endtask

    always @(negedge clk) begin
        if (resetb) begin
            bit vis;
            chk("ireqready", 64'(ireqready_o), 64'(exp_ready));
            chk("mem_en", 64'(mem_en_o), 64'(exp_mem_en));
            if (exp_mem_en) chk("mem_addr", 64'(mem_addr_o), 64'(exp_mem_addr));
            vis = (sb_q.size() > 0) && (sb_q[0].ready_at <= en_cnt);
            chk("irspvalid", 64'(irspvalid_o), 64'(vis));
            if (vis) begin
                chk("rsp_rerr", 64'(irsprerr_o), 64'(sb_q[0].rerr));
                chk("rsp_data", 64'(irspdata_o), 64'(sb_q[0].data));
            end else begin
                chk("idle_rerr", 64'(irsprerr_o), 64'h0);
                chk("idle_data", 64'(irspdata_o), 64'h0);
            end
            if (clk_en && irspvalid_o && irspready) rsp_seen++;
            if (clk_en && ireqvalid && ireqready_o) dut_acc++;
            if (clk_en && vis && irspready) void'(sb_q.pop_front());
            if (clk_en) en_cnt++;
        end
    end

    initial begin
        int unsigned a0;
        for (int unsigned i = 0; i < WORDS; i++) mem_arr[i] = $urandom();

        #2;
        chk("reset_valid", 64'(irspvalid_o), 64'h0);
        chk("reset_rerr", 64'(irsprerr_o), 64'h0);
        chk("reset_data", 64'(irspdata_o), 64'h0);
        chk("reset_mem_en", 64'(mem_en_o), 64'h0);
        chk("reset_ready", 64'(ireqready_o), 64'h1);
        idle(2, 1'b1);
        resetb = 1'b1;

        // Back-to-back fetches of words 0,1,2 with a ready consumer
        step(1'b1, BASE + 32'h0, 2'b11, 1'b1, 1'b1);
        step(1'b1, BASE + 32'h4, 2'b11, 1'b1, 1'b1);
        step(1'b1, BASE + 32'h8, 2'b11, 1'b1, 1'b1);
        idle(5, 1'b1);

        // Stalled consumer: only DEPTH requests fit
        a0 = dut_acc;
        for (int unsigned i = 0; i < 8; i++) step(1'b1, BASE + 32'(4 * (i + 8)), 2'b11, 1'b1, 1'b0);
        chk("stall_accepts", 64'(dut_acc - a0), 64'(DEPTH));
        chk("stall_ready_low", 64'(ireqready_o), 64'h0);
        idle(8, 1'b1);
        chk("release_ready", 64'(ireqready_o), 64'h1);

        // Misaligned, past-top and below-base addresses
        step(1'b1, BASE + 32'h2, 2'b11, 1'b1, 1'b1);
        step(1'b1, BASE + 32'(4 * WORDS), 2'b11, 1'b1, 1'b1);
        step(1'b1, BASE - 32'h4, 2'b11, 1'b1, 1'b1);
        step(1'b1, BASE + 32'(4 * WORDS - 4), 2'b11, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Privilege gate
        step(1'b1, BASE + 32'h10, 2'b00, 1'b1, 1'b1);
        step(1'b1, BASE + 32'h10, 2'b11, 1'b1, 1'b1);
        step(1'b1, BASE + 32'h14, 2'b10, 1'b1, 1'b1);
        step(1'b1, BASE + 32'h14, 2'b01, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Clock enable toggling 1010 during a stream
        for (int unsigned i = 0; i < 16; i++)
            step(1'b1, BASE + 32'(4 * i), 2'b11, (i % 2) == 0, 1'b1);
        idle(5, 1'b1);

        // Random traffic
        for (int unsigned i = 0; i < 400; i++) begin
            int unsigned r;
            logic [31:0] a;
            logic [1:0]  h;
            r = $urandom_range(0, 9);
            if (r < 7)       a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
            else if (r == 7) a = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
            else if (r == 8) a = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 15));
            else             a = $urandom();
            h = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            step($urandom_range(0, 3) != 0, a, h, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) != 0);
        end
        idle(8, 1'b1);

        // Reset with three queued responses
        for (int unsigned i = 0; i < 3; i++) step(1'b1, BASE + 32'(4 * i), 2'b11, 1'b1, 1'b0);
        idle(3, 1'b0);
        @(posedge clk);
        #1;
        resetb = 1'b0;
        #1;
        chk("midreset_valid", 64'(irspvalid_o), 64'h0);
        chk("midreset_ready", 64'(ireqready_o), 64'h1);
        chk("midreset_data", 64'(irspdata_o), 64'h0);
        dropped += sb_q.size();
        sb_q.delete();
        exp_ready  = 1'b1;
        exp_mem_en = 1'b0;
        idle(2, 1'b1);
        resetb = 1'b1;

        step(1'b1, BASE + 32'h20, 2'b11, 1'b1, 1'b1);
        step(1'b1, BASE + 32'h24, 2'b11, 1'b1, 1'b1);
        for (int unsigned i = 0; i < 40 && sb_q.size() != 0; i++) idle(1, 1'b1);
        idle(2, 1'b1);
        chk("responses_returned", 64'(rsp_seen), 64'(acc_cnt - dropped));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
